// File: rtl/fir_ctrl_pkg.sv
// Shared types and helpers for the folded FIR sequencer: state encoding,
// data widths and the circular-buffer pointer decrement.
package fir_ctrl_pkg;

    localparam int SAMPLE_W = 16;
    localparam int ACC_W    = 32;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        RUN,
        DRAIN,
        OUT
    } state_t;

    // Step a pointer backwards through 0..modulus-1, wrapping 0 to modulus-1.
    function automatic logic [15:0] mod_dec(input logic [15:0] val, input logic [15:0] modulus);
        return (val == 16'd0) ? (modulus - 16'd1) : (val - 16'd1);
    endfunction

endpackage

// File: rtl/fir_tap_addr_gen.sv
// Tap counter and down-counting circular read pointer for one folded FIR pass,
// starting at the newest sample and walking back through the history.
module fir_tap_addr_gen
    import fir_ctrl_pkg::*;
#(
    parameter int TAP_NUM = 321,
    parameter int ADDR_W  = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] newest,
    output logic [ADDR_W-1:0] k,
    output logic [ADDR_W-1:0] rd_ptr,
    output logic              last_tap
);

    logic [ADDR_W-1:0] k_reg;
    logic [ADDR_W-1:0] rd_ptr_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k_reg      <= '0;
            rd_ptr_reg <= '0;
        end else if (load) begin
            k_reg      <= '0;
            rd_ptr_reg <= newest;
        end else if (step) begin
            k_reg      <= k_reg + ADDR_W'(1);
            rd_ptr_reg <= ADDR_W'(mod_dec(16'(rd_ptr_reg), 16'(TAP_NUM)));
        end
    end

    assign k        = k_reg;
    assign rd_ptr   = rd_ptr_reg;
    assign last_tap = (k_reg == ADDR_W'(TAP_NUM - 1));

endmodule

// File: rtl/fir_fold_ctrl.sv
// Sequencer for a folded FIR: clears the sample buffer after reset, stores one
// sample per frame, streams TAP_NUM operand pairs into an external MAC and hands off the sum.
module fir_fold_ctrl
    import fir_ctrl_pkg::*;
#(
    parameter int TAP_NUM = 321,
    parameter int ADDR_W  = 9,
    parameter int MAC_LAT = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SAMPLE_W-1:0] in_data,
    output logic                smp_we,
    output logic [ADDR_W-1:0]   smp_waddr,
    output logic [SAMPLE_W-1:0] smp_wdata,
    output logic [ADDR_W-1:0]   smp_raddr,
    output logic [ADDR_W-1:0]   coef_raddr,
    output logic                mac_clr,
    output logic                mac_en,
    input  logic [ACC_W-1:0]    acc_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ACC_W-1:0]    out_data,
    output logic                busy
);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] wr_ptr_reg;
    logic [ADDR_W-1:0] cnt_reg;
    logic [7:0]        drain_cnt_reg;
    logic              mac_en_reg;
    logic              mac_clr_reg;
    logic              out_valid_reg;
    logic [ACC_W-1:0]  out_data_reg;

    logic              accept;
    logic              drain_done;
    logic [ADDR_W-1:0] tap_k;
    logic [ADDR_W-1:0] tap_ptr;
    logic              last_tap;

    assign accept     = (state_reg == IDLE) && in_valid;
    assign drain_done = (state_reg == DRAIN) && (drain_cnt_reg == 8'(MAC_LAT));

    fir_tap_addr_gen #(
        .TAP_NUM (TAP_NUM),
        .ADDR_W  (ADDR_W)
    ) u_tap_addr_gen (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .step     (state_reg == RUN),
        .newest   (wr_ptr_reg),
        .k        (tap_k),
        .rd_ptr   (tap_ptr),
        .last_tap (last_tap)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= INIT;
            wr_ptr_reg    <= '0;
            cnt_reg       <= '0;
            drain_cnt_reg <= '0;
            mac_en_reg    <= 1'b0;
            mac_clr_reg   <= 1'b0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == INIT)
                cnt_reg <= cnt_reg + ADDR_W'(1);
            if (accept)
                wr_ptr_reg <= (wr_ptr_reg == ADDR_W'(TAP_NUM - 1)) ? '0 : wr_ptr_reg + ADDR_W'(1);
            drain_cnt_reg <= (state_reg == DRAIN) ? drain_cnt_reg + 8'd1 : 8'd0;
            // Operands arrive one cycle after the addresses, so the MAC strobes lag by one.
            mac_en_reg    <= (state_reg == RUN);
            mac_clr_reg   <= (state_reg == RUN) && (tap_k == '0);
            if (drain_done) begin
                out_data_reg  <= acc_in;
                out_valid_reg <= 1'b1;
            end else if (out_valid_reg && out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        smp_we     = 1'b0;
        smp_waddr  = wr_ptr_reg;
        smp_wdata  = '0;
        case (state_reg)
            INIT: begin
                // No buffer writes while reset is still held.
                smp_we    = ~reset;
                smp_waddr = cnt_reg;
                if (cnt_reg == ADDR_W'(TAP_NUM - 1))
                    state_next = IDLE;
            end
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    smp_we     = 1'b1;
                    smp_wdata  = in_data;
                    state_next = RUN;
                end
            end
            RUN:     if (last_tap)   state_next = DRAIN;
            DRAIN:   if (drain_done) state_next = OUT;
            OUT:     if (out_ready)  state_next = IDLE;
            default: state_next = INIT;
        endcase
    end

    assign smp_raddr  = tap_ptr;
    assign coef_raddr = tap_k;
    assign mac_en     = mac_en_reg;
    assign mac_clr    = mac_clr_reg;
    assign out_valid  = out_valid_reg;
    assign out_data   = out_data_reg;
    assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_fir_fold_ctrl.sv
// Bench for fir_fold_ctrl with behavioural sample RAM, coefficient ROM and
// two-stage MAC; expected filter outputs come from a direct convolution model.
module tb_fir_fold_ctrl;

    localparam int TAP = 21;
    localparam int AW  = 5;
    localparam int LAT = 2;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        smp_we;
    logic [AW-1:0] smp_waddr;
    logic [15:0] smp_wdata;
    logic [AW-1:0] smp_raddr;
    logic [AW-1:0] coef_raddr;
    logic        mac_clr;
    logic        mac_en;
    logic [31:0] acc_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    fir_fold_ctrl #(
        .TAP_NUM (TAP),
        .ADDR_W  (AW),
        .MAC_LAT (LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .smp_we     (smp_we),
        .smp_waddr  (smp_waddr),
        .smp_wdata  (smp_wdata),
        .smp_raddr  (smp_raddr),
        .coef_raddr (coef_raddr),
        .mac_clr    (mac_clr),
        .mac_en     (mac_en),
        .acc_in     (acc_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural memories: synchronous read, new data on a same-address write.
    logic signed [15:0] ram [0:(1<<AW)-1];
    logic signed [15:0] rom [0:(1<<AW)-1];
    logic signed [15:0] ram_q, rom_q;
    always @(posedge clk) begin
        if (smp_we) ram[smp_waddr] <= smp_wdata;
        ram_q <= (smp_we && smp_waddr == smp_raddr) ? smp_wdata : ram[smp_raddr];
        rom_q <= rom[coef_raddr];
    end

    // MAC: product register, then accumulate; acc_in updates LAT cycles after mac_en.
    logic signed [31:0] prod, acc;
    logic p_v, p_clr;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            p_v <= 1'b0; p_clr <= 1'b0; prod <= '0; acc <= '0;
        end else begin
            p_v   <= mac_en;
            p_clr <= mac_clr;
            prod  <= ram_q * rom_q;
            if (p_v) acc <= p_clr ? prod : acc + prod;
        end
    end
    assign acc_in = acc;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    logic [31:0] sb[$];
    int          hist[$];
    int          n_acc = 0;
    int          acc_cyc = 0;

    task automatic send(input logic signed [15:0] d, input int run_k);
        int     n;
        int     newest;
        longint s;
        n = 0;
        s = 0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && n < 500) begin
            chk("hold_no_we", 64'(smp_we), 64'(0));
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", 64'(n < 500), 64'(1));
        hist.push_front(int'(d));
        if (hist.size() > TAP) void'(hist.pop_back());
        for (int k = 0; k < TAP && k < hist.size(); k++)
            s += longint'(rom[k]) * longint'(hist[k]);
        sb.push_back(32'(s));
        acc_cyc = cyc;
        newest  = n_acc % TAP;
        n_acc++;
        $display("tb: accept #%0d data=%0d newest=%0d expect=%0d", n_acc, d, newest, s);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 0; k < run_k; k++) begin
            @(negedge clk);
            chk("run_smp_raddr", 64'(smp_raddr), 64'((newest - k + TAP) % TAP));
            chk("run_coef_raddr", 64'(coef_raddr), 64'(k));
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_in_ready",  64'(in_ready),  64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data",  64'(out_data),  64'(0));
        chk("rst_smp_we",    64'(smp_we),    64'(0));
        chk("rst_mac_en",    64'(mac_en),    64'(0));
        chk("rst_mac_clr",   64'(mac_clr),   64'(0));
        chk("rst_busy",      64'(busy),      64'(1));
    endtask

    task automatic init_check();
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < TAP; i++) begin
            @(negedge clk);
            chk("init_sweep", 64'({in_ready, smp_we, smp_waddr, smp_wdata}),
                64'({1'b0, 1'b1, AW'(i), 16'h0000}));
        end
        @(negedge clk);
        chk("init_done_ready", 64'(in_ready), 64'(1));
        chk("init_done_busy",  64'(busy),     64'(0));
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 64'(n < 2000), 64'(1));
    endtask

    // Output side of the scoreboard plus first-result latency.
    logic ov_prev = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            ov_prev <= 1'b0;
        end else begin
            if (out_valid && !ov_prev)
                chk("latency", 64'(cyc - acc_cyc), 64'(TAP + LAT + 2));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_out", 64'(1), 64'(0));
                end else begin
                    logic [31:0] e;
                    e = sb.pop_front();
                    chk("out_data", 64'(out_data), 64'(e));
                    $display("tb: result out=%0d expect=%0d", $signed(out_data), $signed(e));
                end
            end
            ov_prev <= out_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        for (int i = 0; i < (1 << AW); i++) rom[i] = 16'sd3;
        repeat (3) @(negedge clk);
        chk_reset_vals();
        init_check();

        // DC input through the wrap of the write pointer (30 accepts -> newest 8).
        for (int i = 0; i < TAP + 9; i++) send(16'sd2, TAP);
        wait_empty();

        // Backpressure held in OUT.
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(16'sd7, TAP);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid_timeout", 64'(out_valid), 64'(1));
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("bp_data", 64'(out_data), 64'(sb[0]));
            chk("bp_hold", 64'({out_valid, in_ready, smp_we}), 64'(3'b100));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_idle", 64'(in_ready), 64'(1));
        wait_empty();

        // Abort mid-RUN, then impulse response with coef[k] = k+1.
        send(16'sd5, 10);
        reset = 1'b1;
        sb.delete();
        hist.delete();
        n_acc = 0;
        #1;
        chk_reset_vals();
        for (int i = 0; i < (1 << AW); i++) rom[i] = 16'(i + 1);
        repeat (3) @(negedge clk);
        init_check();
        send(16'sd1, TAP);
        for (int i = 0; i < 5; i++) send(16'sd0, TAP);
        wait_empty();

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
